// File: rtl/mac_combiner_pipe.sv
// Two-stage partial-product combiner: merges groups of 2^cfg lanes into wide
// results (shift-by-MIN_WIDTH and add) with valid/ready flow and a global stall.
module mac_combiner_pipe #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned MIN_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned CFG_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CFG_W-1:0]           cfg,
  input  logic [LANES*ACC_WIDTH-1:0] partial,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out,
  output logic                       out_err
);

  localparam int unsigned TOT_W = LANES * ACC_WIDTH;
  localparam int unsigned LOG2L = $clog2(LANES);

  logic               s1_valid;
  logic [TOT_W-1:0]   s1_partial;
  logic [CFG_W-1:0]   s1_cfg;
  logic               s2_free;
  logic               s1_move;
  logic               accept;
  logic [TOT_W-1:0]   comb_sum;
  logic               comb_err;
  logic [TOT_W-1:0]   acc;
  logic [TOT_W-1:0]   mask;
  int unsigned        eff;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = en && in_valid && in_ready;
  assign s1_move  = en && s1_valid && s2_free;

  // Group math on the stage-1 beat; reserved cfg falls back to pass-through.
  always_comb begin
    comb_err = (32'(s1_cfg) > LOG2L);
    eff      = comb_err ? 32'd0 : 32'(s1_cfg);
    comb_sum = '0;
    acc      = '0;
    mask     = '0;
    for (int unsigned c = 0; c <= LOG2L; c++) begin
      if (c == eff) begin
        for (int unsigned g = 0; g < (LANES >> c); g++) begin
          acc = '0;
          for (int unsigned j = 0; j < (32'd1 << c); j++) begin
            acc = acc + (TOT_W'(s1_partial[(g * (32'd1 << c) + j) * ACC_WIDTH +: ACC_WIDTH])
                         << (j * MIN_WIDTH));
          end
          mask     = {TOT_W{1'b1}} >> (TOT_W - (ACC_WIDTH << c));
          comb_sum = comb_sum | ((acc & mask) << (g * (ACC_WIDTH << c)));
        end
      end
    end
  end

  // Pipeline registers; rst wins over en, en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_partial <= '0;
      s1_cfg     <= '0;
      out_valid  <= 1'b0;
      out        <= '0;
      out_err    <= 1'b0;
    end else if (en) begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_partial <= partial;
        s1_cfg     <= cfg;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (s1_move) begin
        out_valid <= 1'b1;
        out       <= comb_sum;
        out_err   <= comb_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_combiner_pipe.sv
// Scoreboard bench for mac_combiner_pipe (LANES=4, MIN_WIDTH=8, ACC_WIDTH=32).
module tb_mac_combiner_pipe;

  typedef struct {
    logic [127:0] d;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, en, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]   cfg;
  logic [127:0] partial, out;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   delivered = 0;

  always #5 clk = ~clk;

  mac_combiner_pipe #(.LANES(4), .MIN_WIDTH(8), .ACC_WIDTH(32), .CFG_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .cfg(cfg), .partial(partial), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic exp_t mk(input logic [127:0] d, input logic e);
    exp_t r;
    r.d = d;
    r.e = e;
    return r;
  endfunction

  // Reference: each group summed with lane weights 2^(8j), reduced mod 2^(32G)
  function automatic exp_t model(input logic [1:0] cf, input logic [127:0] p);
    exp_t r;
    int gs;
    logic [127:0] s;
    r.e = (cf == 2'd3);
    gs  = r.e ? 1 : (1 << cf);
    r.d = '0;
    for (int g = 0; g < 4 / gs; g++) begin
      s = '0;
      for (int j = 0; j < gs; j++)
        s = s + ({96'd0, p[(g * gs + j) * 32 +: 32]} * (128'd1 << (8 * j)));
      if (gs < 4) s = s % (128'd1 << (32 * gs));
      r.d = r.d | (s << (32 * g * gs));
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] cf, input logic [127:0] p, input exp_t ex);
    bit ok = 1'b0;
    cfg      = cf;
    partial  = p;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready && en && !rst;
    end
    if (ok) q.push_back(ex);
    else chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input int maxcfg);
    logic [1:0]   cf;
    logic [127:0] p;
    cf = 2'($urandom_range(0, maxcfg));
    p  = {$urandom, $urandom, $urandom, $urandom};
    send(cf, p, model(cf, p));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
    chk(tag, 128'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops on every handshake, checks stability while stalled
  initial begin
    logic         held;
    logic [127:0] hd;
    logic         he;
    exp_t         x;
    held = 1'b0;
    hd   = '0;
    he   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        held = 1'b0;
      end else if (en) begin
        if (held) begin
          chk("hold_data", out, hd);
          chk("hold_err", 128'(out_err), 128'(he));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            x = q.pop_front();
            chk("out_data", out, x.d);
            chk("out_err", 128'(out_err), 128'(x.e));
            delivered++;
          end
        end
        held = out_valid && !out_ready;
        hd   = out;
        he   = out_err;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; cfg = '0; partial = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_out", out, 0);
    chk("rst_out_err", 128'(out_err), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 1);

    // single mode with latency check
    send(2'd0, pack4(1, 2, 3, 4), mk(pack4(1, 2, 3, 4), 1'b0));
    chk("lat_s1", 128'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_s2", 128'(out_valid), 1);
    drain("drain_single");

    // dual and quad carry
    send(2'd1, pack4(32'hFF, 32'h1, 32'h10, 32'h1), mk(pack4(32'h1FF, 0, 32'h110, 0), 1'b0));
    send(2'd2, pack4(32'hFFFFFFFF, 32'h01000000, 0, 0), mk(pack4(32'hFFFFFFFF, 1, 0, 0), 1'b0));
    drain("drain_modes");

    // backpressure: 6 beats, out_ready low for 4 cycles
    base = delivered;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(2);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", 128'(in_ready), 0);
        chk("bp_out_valid", 128'(out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_count", 128'(delivered - base), 6);

    // reserved cfg then a normal beat
    send(2'd3, pack4(5, 6, 7, 8), mk(pack4(5, 6, 7, 8), 1'b1));
    send(2'd0, pack4(9, 10, 11, 12), mk(pack4(9, 10, 11, 12), 1'b0));
    drain("drain_rsv");

    // reset with two beats in flight
    out_ready = 1'b0;
    send(2'd0, pack4(1, 1, 1, 1), mk(pack4(1, 1, 1, 1), 1'b0));
    send(2'd0, pack4(2, 2, 2, 2), mk(pack4(2, 2, 2, 2), 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 128'(out_valid), 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", 128'(in_ready), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_idle", 128'(out_valid), 0);

    // en=0 freezes a held result and blocks accepts
    out_ready = 1'b0;
    send(2'd1, pack4(32'h3, 32'h2, 0, 0), mk(pack4(32'h203, 0, 0, 0), 1'b0));
    @(posedge clk);
    #1;
    en = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    cfg = 2'd0;
    partial = pack4(7, 7, 7, 7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("frz_valid", 128'(out_valid), 1);
      chk("frz_out", out, pack4(32'h203, 0, 0, 0));
    end
    in_valid = 1'b0;
    en = 1'b1;
    drain("drain_frz");
    repeat (3) @(posedge clk);
    #1;
    chk("frz_no_accept", 128'(out_valid), 0);

    // random mixed modes with random backpressure
    base = delivered;
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(3);
      end
      begin
        for (int i = 0; i < 80; i++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_rand");
    chk("rand_count", 128'(delivered - base), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
